// File: rtl/sw_uart_pkg.sv
// Shared register map, status bit positions and FSM state type for the
// SW_Wrapper UART responder.
package sw_uart_pkg;

   localparam logic [4:0] RX_BASE     = 5'h00;
   localparam logic [4:0] TX_BASE     = 5'h04;
   localparam logic [4:0] STATUS_BASE = 5'h08;

   localparam int RRDY_BIT = 7;
   localparam int TRDY_BIT = 6;
   localparam int TOE_BIT  = 4;
   localparam int ROE_BIT  = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/sw_byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count. A push while full is
// dropped even if a pop happens on the same edge; the head reads 0 when empty.
module sw_byte_fifo #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          avm_clk,
   input  logic          avm_rst_n,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [7:0]    head
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge avm_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sw_uart_responder.sv
// Avalon-MM slave exposing the RS232-style RX/TX/status register map to the
// SW_Wrapper polling master, backed by an RX and a TX byte FIFO.
module sw_uart_responder
   import sw_uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        avm_clk,
   input  logic        avm_rst_n,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state;
   state_t        next_state;
   logic [2:0]    cnt;
   logic [4:0]    addr_q;
   logic          read_q;
   logic          rx_avail_q;
   logic          toe;
   logic          roe;

   logic [4:0]    eff_addr;
   logic          eff_read;
   logic [31:0]   resp_data;
   logic [31:0]   status_word;
   logic [31:0]   rx_count_ext;
   logic [4:0]    rx_count_sat;

   logic          rx_full, rx_empty, tx_full, tx_empty;
   logic [CW-1:0] rx_count, tx_count;
   logic [7:0]    rx_head;
   logic          rx_pop, tx_push, tx_pop;
   logic          set_roe, set_toe, clr_err;
   logic          unused_bits;

   assign rx_ready    = !rx_full;
   assign tx_valid    = !tx_empty;
   assign tx_pop      = tx_valid && tx_ready;
   assign unused_bits = ^{avs_writedata[31:8], tx_count};

   sw_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .avm_clk   (avm_clk),
      .avm_rst_n (avm_rst_n),
      .push      (rx_valid && rx_ready),
      .wdata     (rx_data),
      .pop       (rx_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count),
      .head      (rx_head)
   );

   sw_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .avm_clk   (avm_clk),
      .avm_rst_n (avm_rst_n),
      .push      (tx_push),
      .wdata     (avs_writedata[7:0]),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count),
      .head      (tx_data)
   );

   // State register
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; waitrequest drops only while in RESP
   always_comb begin
      next_state      = state;
      avs_waitrequest = 1'b1;
      case (state)
         IDLE: begin
            if (avs_read || avs_write) begin
               next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               next_state = RESP;
            end
         end
         RESP: begin
            avs_waitrequest = 1'b0;
            next_state      = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Latch the access on acceptance so a master dropping the request mid-WAIT still completes
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         cnt    <= 3'd0;
         addr_q <= 5'd0;
         read_q <= 1'b0;
      end else if (state == IDLE && (avs_read || avs_write)) begin
         addr_q <= avs_address;
         read_q <= avs_read;
         cnt    <= (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   // Status word; rx_count saturates at the 5-bit field
   always_comb begin
      rx_count_ext          = 32'(rx_count);
      rx_count_sat          = (rx_count_ext > 32'd31) ? 5'd31 : rx_count_ext[4:0];
      status_word           = '0;
      status_word[12:8]     = rx_count_sat;
      status_word[RRDY_BIT] = !rx_empty;
      status_word[TRDY_BIT] = !tx_full;
      status_word[TOE_BIT]  = toe;
      status_word[ROE_BIT]  = roe;
   end

   // Readdata mux; uses live inputs when RESP is entered straight from IDLE
   always_comb begin
      eff_addr  = (state == IDLE) ? avs_address : addr_q;
      eff_read  = (state == IDLE) ? avs_read : read_q;
      resp_data = '0;
      if (eff_read) begin
         if (eff_addr == RX_BASE) begin
            resp_data = {24'h0, rx_head};
         end else if (eff_addr == STATUS_BASE) begin
            resp_data = status_word;
         end
      end
   end

   // Snapshot readdata and RX availability on the edge that enters RESP
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         avs_readdata <= '0;
         rx_avail_q   <= 1'b0;
      end else if (state != RESP && next_state == RESP) begin
         avs_readdata <= resp_data;
         rx_avail_q   <= !rx_empty;
      end
   end

   // Side effects are decided in RESP and take place on its exit edge
   always_comb begin
      rx_pop  = 1'b0;
      tx_push = 1'b0;
      set_roe = 1'b0;
      set_toe = 1'b0;
      clr_err = 1'b0;
      if (state == RESP) begin
         if (read_q) begin
            if (addr_q == RX_BASE) begin
               rx_pop  = rx_avail_q;
               set_roe = !rx_avail_q;
            end
         end else if (addr_q == TX_BASE) begin
            tx_push = 1'b1;
            set_toe = tx_full;
         end else if (addr_q == STATUS_BASE) begin
            clr_err = 1'b1;
         end
      end
   end

   // Sticky overrun flags, cleared by a status write
   always_ff @(posedge avm_clk or negedge avm_rst_n) begin
      if (!avm_rst_n) begin
         toe <= 1'b0;
         roe <= 1'b0;
      end else if (clr_err) begin
         toe <= 1'b0;
         roe <= 1'b0;
      end else begin
         toe <= toe | set_toe;
         roe <= roe | set_roe;
      end
   end

endmodule
